// File: rtl/apple_kbd_typeahead_ctrl_if.sv
// Keyboard typeahead bus: decoder/CPU-side controls in, $C000 view and queue status out.
interface apple_kbd_typeahead_ctrl_if #(
  parameter int unsigned FIFO_AW = 3
);
  logic               KEY_VALID;
  logic [6:0]         KEY_ASCII;
  logic               KEY_HELD;
  logic               REPEAT_EN;
  logic               TICK;
  logic               CLR_STB;
  logic               FLUSH;
  logic               CLR_OVF;
  logic [7:0]         KBD_DATA;
  logic               STROBE;
  logic [FIFO_AW:0]   FIFO_COUNT;
  logic               OVERFLOW;

  modport master (
    output KEY_VALID, KEY_ASCII, KEY_HELD, REPEAT_EN, TICK, CLR_STB, FLUSH, CLR_OVF,
    input  KBD_DATA, STROBE, FIFO_COUNT, OVERFLOW
  );

  modport slave (
    input  KEY_VALID, KEY_ASCII, KEY_HELD, REPEAT_EN, TICK, CLR_STB, FLUSH, CLR_OVF,
    output KBD_DATA, STROBE, FIFO_COUNT, OVERFLOW
  );
endinterface

// File: rtl/apple_kbd_typeahead_ctrl.sv
// Typeahead FIFO and auto-repeat scheduler feeding the Apple $C000/$C010 keyboard latch.
module apple_kbd_typeahead_ctrl #(
  parameter int unsigned FIFO_AW      = 3,
  parameter int unsigned REPEAT_DELAY = 40,
  parameter int unsigned REPEAT_RATE  = 6
) (
  input  logic                        KB_CLK,
  input  logic                        SYS_RESET,
  apple_kbd_typeahead_ctrl_if.slave   kbd
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned TMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RPT   = 2'd2
  } rpt_state_e;

  logic [6:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      count;
  logic               strobe;
  logic [6:0]         cur_ascii;
  logic [6:0]         rep_ascii;
  logic               overflow;

  rpt_state_e         state;
  rpt_state_e         state_nxt;
  logic [TW-1:0]      tcnt;
  logic [TW-1:0]      tcnt_nxt;
  logic               rep_event_c;

  logic               fifo_empty_c;
  logic               fifo_full_c;
  logic               pop_c;
  logic               key_push_c;
  logic               rep_push_c;
  logic               push_c;
  logic               drop_c;
  logic [6:0]         push_data_c;
  logic               rpt_abort_c;

  // FIFO control; a pop frees a slot on the same edge, so full+pop still accepts a key
  always_comb begin
    fifo_empty_c = (count == '0);
    fifo_full_c  = (count == CW'(DEPTH));
    pop_c        = !strobe && !fifo_empty_c && !kbd.FLUSH;
    key_push_c   = kbd.KEY_VALID && !kbd.FLUSH && (!fifo_full_c || pop_c);
    drop_c       = kbd.KEY_VALID && !kbd.FLUSH && fifo_full_c && !pop_c;
    rep_push_c   = rep_event_c && fifo_empty_c;
    push_c       = key_push_c || rep_push_c;
    push_data_c  = key_push_c ? kbd.KEY_ASCII : rep_ascii;
  end

  always_ff @(posedge KB_CLK) begin
    if (push_c) begin
      fifo_mem[wr_ptr] <= push_data_c;
    end
  end

  always_ff @(posedge KB_CLK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      strobe    <= 1'b0;
      cur_ascii <= 7'h00;
      overflow  <= 1'b0;
      rep_ascii <= 7'h00;
    end else begin
      if (kbd.FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_c) begin
          wr_ptr <= wr_ptr + FIFO_AW'(1);
        end
        if (pop_c) begin
          rd_ptr <= rd_ptr + FIFO_AW'(1);
        end
        count <= count + CW'(push_c) - CW'(pop_c);
      end

      // Load only happens while STROBE is low, so it never collides with CLR_STB
      if (kbd.FLUSH) begin
        strobe <= 1'b0;
      end else if (pop_c) begin
        strobe    <= 1'b1;
        cur_ascii <= fifo_mem[rd_ptr];
      end else if (kbd.CLR_STB) begin
        strobe <= 1'b0;
      end

      if (drop_c) begin
        overflow <= 1'b1;
      end else if (kbd.CLR_OVF) begin
        overflow <= 1'b0;
      end

      if (kbd.KEY_VALID) begin
        rep_ascii <= kbd.KEY_ASCII;
      end
    end
  end

  // Repeat FSM: state register
  always_ff @(posedge KB_CLK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  assign rpt_abort_c = kbd.FLUSH || kbd.KEY_VALID || !kbd.KEY_HELD || !kbd.REPEAT_EN;

  // Repeat FSM: next state
  always_comb begin
    state_nxt = state;
    if (kbd.FLUSH) begin
      state_nxt = ST_IDLE;
    end else if (kbd.KEY_VALID) begin
      state_nxt = ST_DELAY;
    end else if (!kbd.KEY_HELD || !kbd.REPEAT_EN) begin
      state_nxt = ST_IDLE;
    end else if (state == ST_DELAY && kbd.TICK && tcnt == TW'(REPEAT_DELAY - 1)) begin
      state_nxt = ST_RPT;
    end
  end

  // Repeat FSM: tick counter and repeat event
  always_comb begin
    tcnt_nxt    = tcnt;
    rep_event_c = 1'b0;
    if (rpt_abort_c) begin
      tcnt_nxt = '0;
    end else begin
      unique case (state)
        ST_DELAY: begin
          if (kbd.TICK) begin
            if (tcnt == TW'(REPEAT_DELAY - 1)) begin
              rep_event_c = 1'b1;
              tcnt_nxt    = '0;
            end else begin
              tcnt_nxt = tcnt + TW'(1);
            end
          end
        end
        ST_RPT: begin
          if (kbd.TICK) begin
            if (tcnt == TW'(REPEAT_RATE - 1)) begin
              rep_event_c = 1'b1;
              tcnt_nxt    = '0;
            end else begin
              tcnt_nxt = tcnt + TW'(1);
            end
          end
        end
        default: tcnt_nxt = '0;
      endcase
    end
  end

  assign kbd.KBD_DATA   = {strobe, cur_ascii};
  assign kbd.STROBE     = strobe;
  assign kbd.FIFO_COUNT = count;
  assign kbd.OVERFLOW   = overflow;

endmodule
